ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch unit: the consumer end of the program-counter interface. It accepts fetch addresses from the PC stage over a valid/ready handshake, reads a synchronous instruction ROM with one-cycle latency, and delivers {pc, instr} pairs to decode through a small output FIFO. It supports branch/jump redirect flushes and flags misaligned or out-of-range fetches.

## Interface
Parameters:
- IMEM_AW, 10, instruction ROM word-address width (ROM holds 2^IMEM_AW words)
- FIFO_DEPTH, 2, output FIFO entries (minimum 2, power of two)
- NOP_INSTR, 32'h0000_0013, instruction substituted on error (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  PC stage presents a fetch address
- req_pc  in  32  byte address to fetch
- req_ready  out  1  unit accepts req_pc this cycle
- flush  in  1  redirect: discard all queued and in-flight fetches
- mem_en  out  1  ROM read enable
- mem_addr  out  IMEM_AW  ROM word address
- mem_rdata  in  32  ROM data, valid the cycle after mem_en
- rsp_valid  out  1  head FIFO entry available
- rsp_pc  out  32  PC of head entry
- rsp_instr  out  32  instruction of head entry
- rsp_err  out  1  head entry is a misaligned or out-of-range fetch
- rsp_ready  in  1  decode consumes head entry

## Operation
- Accept = req_valid && req_ready. On accept: mem_en=1, mem_addr=req_pc[IMEM_AW+1:2], register {req_pc, err} into the in-flight stage (inflight=1).
- err = req_pc[1:0]!=0 or req_pc[31:IMEM_AW+2]!=0. An err request still occupies a slot; mem_en is 0 for it; its entry carries instr=NOP_INSTR, rsp_err=1.
- Cycle after accept: in-flight entry is written to the FIFO tail with mem_rdata (or NOP_INSTR on err), and inflight clears unless a new accept occurs in the same cycle.
- pop = rsp_valid && rsp_ready; removes the head.
- Credit: req_ready = !flush && rst_n && (fifo_count + inflight - pop) < FIFO_DEPTH. Guarantees the FIFO never overflows; no data is ever dropped except by flush.
- flush (priority over all else): next cycle fifo_count=0, inflight=0, rsp_valid=0; req_ready=0 in the flush cycle; pop in the flush cycle is ignored (entry discarded with the rest). Returning mem_rdata for a flushed in-flight fetch is discarded.
- FIFO: circular buffer, rd/wr pointers of log2(FIFO_DEPTH) bits wrapping modulo depth; count of log2(FIFO_DEPTH)+1 bits. Simultaneous write and pop when full or empty are legal and keep count unchanged (empty case: write then pop is not same-cycle; entry appears next cycle).
- No combinational path mem_rdata -> rsp_*.

## Timing
- Reset (rst_n=0 at an edge): fifo_count=0, pointers=0, inflight=0; rsp_valid=0, rsp_err=0, rsp_pc=0, rsp_instr=0 (outputs gated while empty); req_ready=0 and mem_en=0 while rst_n=0. Reset mid-operation discards everything like flush.
- Latency: accept in cycle N -> rsp_valid in cycle N+2.
- Throughput: one fetch per cycle sustained with rsp_ready held high and FIFO_DEPTH>=2.
- rsp_pc/rsp_instr/rsp_err stable while rsp_valid=1 and rsp_ready=0.
- req_ready depends combinationally on rsp_ready and flush only; mem_en/mem_addr combinational from req_pc and accept.

## Structure
- Shared package (rv_pkg): NOP_INSTR constant, XLEN=32, fetch entry struct {pc[31:0], instr[31:0], err}.
- One sub-module natural: fetch_fifo (parameterised circular FIFO with count, push/pop, clear). Remaining logic (in-flight stage, credit, error check) in ifetch_unit.

## Test plan
- Reset then stream pc 0,4,8,12 with rsp_ready=1, ROM word i = 0x1000+i -> rsp at cycles 2..5: (0,0x1000),(4,0x1001),(8,0x1002),(12,0x1003), rsp_err=0.
- rsp_ready=0 while issuing pc 0,4,8 -> only two accepted (req_ready drops after second), rsp holds (0,0x1000); release rsp_ready -> 0,4 delivered in order, then 8 accepted.
- Issue pc 0x10,0x14, assert flush the cycle after 0x14 accepted -> neither delivered, rsp_valid=0 next cycle; then pc 0x40 -> rsp (0x40, 0x1010) two cycles later.
- req_pc=0x6 -> rsp_err=1, rsp_instr=0x00000013, mem_en=0; req_pc=4<<IMEM_AW -> rsp_err=1.
- Drop rst_n mid-stream with FIFO full -> next cycle rsp_valid=0, req_ready=0 until rst_n=1, then fetch pc 0 returns ROM word 0.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RISC-V front-end definitions. Provides the machine word
//               width, the canonical NOP encoding and the fetch entry record
//               passed from the fetch unit to decode.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int          c_xlen      = 32;
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;   // addi x0,x0,0

    typedef struct packed {
        logic [c_xlen-1:0] pc;
        logic [31:0]       instr;
        logic              err;
    } fetch_entry_t;

    localparam int c_entry_w = $bits(fetch_entry_t);

endpackage : rv_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular FIFO of fetch entries with occupancy count and
//               synchronous clear. The write side is trusted never to push
//               into a full FIFO unless the same cycle also pops.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_clear           - drop all entries (wins over push/pop)
//               i_push / i_wdata  - write one entry at the tail
//               i_pop             - remove the head entry (only when valid)
//               o_valid / o_rdata - head entry present / head entry
//               o_count           - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic                      i_push,
    input  logic [c_entry_w-1:0]      i_wdata,
    input  logic                      i_pop,
    output logic                      o_valid,
    output logic [c_entry_w-1:0]      o_rdata,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_cw-1:0]      r_count;

    // Storage carries no reset: the head is only observed while count != 0.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch unit. Accepts byte fetch addresses from the
//               PC stage, reads a one-cycle-latency instruction ROM and queues
//               {pc, instr, err} entries for decode. Misaligned or
//               out-of-range fetches skip the ROM and return a NOP with err.
//               A flush discards every queued and in-flight fetch.
// Ports       : clk, rst_n                 - clock, synchronous active-low reset
//               req_valid/req_pc/req_ready - fetch address handshake
//               flush                      - redirect, discard all fetches
//               mem_en/mem_addr/mem_rdata  - synchronous ROM port
//               rsp_valid/rsp_pc/rsp_instr/rsp_err/rsp_ready - decode side
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import rv_pkg::*;
#(
    parameter int          IMEM_AW    = 10,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = c_nop_instr
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [31:0]        req_pc,
    output logic               req_ready,
    input  logic               flush,
    output logic               mem_en,
    output logic [IMEM_AW-1:0] mem_addr,
    input  logic [31:0]        mem_rdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_pc,
    output logic [31:0]        rsp_instr,
    output logic               rsp_err,
    input  logic               rsp_ready
);

    localparam int               c_cw    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cw:0]    c_depth = (c_cw + 1)'(FIFO_DEPTH);

    logic               w_err;
    logic               w_accept;
    logic               w_pop;
    logic [c_cw-1:0]    w_count;
    logic [c_cw:0]      w_occ;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    logic               r_inf_valid;
    logic [31:0]        r_inf_pc;
    logic               r_inf_err;

    // Error: low two bits set, or any address bit above the ROM range set.
    assign w_err = (req_pc[1:0] != 2'b00) || (req_pc[31:IMEM_AW+2] != '0);

    // Credit counts the in-flight slot as occupied so the ROM response always
    // has a FIFO entry waiting for it; a same-cycle pop frees one slot.
    assign w_occ = {1'b0, w_count}
                 + {{c_cw{1'b0}}, r_inf_valid}
                 - {{c_cw{1'b0}}, w_pop};
    assign req_ready = !flush && rst_n && (w_occ < c_depth);

    assign w_accept = req_valid && req_ready;
    assign mem_en   = w_accept && !w_err;
    assign mem_addr = req_pc[IMEM_AW+1:2];

    assign w_pop = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_inf_valid <= 1'b0;
            r_inf_pc    <= '0;
            r_inf_err   <= 1'b0;
        end else begin
            r_inf_valid <= w_accept;
            if (w_accept) begin
                r_inf_pc  <= req_pc;
                r_inf_err <= w_err;
            end
        end
    end

    // ROM data is captured straight into the FIFO, so decode never sees a
    // combinational path from mem_rdata.
    assign w_push_entry.pc    = r_inf_pc;
    assign w_push_entry.instr = r_inf_err ? NOP_INSTR : mem_rdata;
    assign w_push_entry.err   = r_inf_err;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (flush),
        .i_push  (r_inf_valid),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_valid (rsp_valid),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // Payload is forced to zero whenever the FIFO is empty.
    assign rsp_pc    = rsp_valid ? w_head.pc    : 32'h0;
    assign rsp_instr = rsp_valid ? w_head.instr : 32'h0;
    assign rsp_err   = rsp_valid && w_head.err;

endmodule : ifetch_unit
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Scoreboard testbench for ifetch_unit. Accepted fetches are
//               turned into expected responses by an address-level model and
//               queued; the monitor compares every response the unit offers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam int          AW    = 10;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic [31:0]       req_pc = 32'h0;
    logic              req_ready;
    logic              flush = 1'b0;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_rdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_pc;
    logic [31:0]       rsp_instr;
    logic              rsp_err;
    logic              rsp_ready = 1'b0;

    ifetch_unit #(
        .IMEM_AW    (AW),
        .FIFO_DEPTH (DEPTH),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .flush     (flush),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_pc    (rsp_pc),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    // Instruction ROM: word i holds 0x1000+i; garbage when not enabled.
    logic [31:0] rom [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 32'h1000 + i;
    end
    always @(posedge clk) mem_rdata <= mem_en ? rom[mem_addr] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          err;
        int          acc_cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    function automatic bit model_err(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= 32'(4 * (1 << AW)));
    endfunction

    // Monitor / scoreboard, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        bit   exp_v, exp_pop, exp_rdy, acc, e;
        exp_t ent;
        cyc++;
        if (!rst_n) begin
            chk(req_ready == 1'b0, "ready_in_reset", 32'(req_ready), 32'h0);
            chk(mem_en == 1'b0, "mem_en_in_reset", 32'(mem_en), 32'h0);
            q.delete();
        end else begin
            // An entry becomes visible two cycles after its accept cycle.
            exp_v   = (q.size() > 0) && (q[0].acc_cyc + 2 <= cyc);
            exp_pop = exp_v && rsp_ready && !flush;
            exp_rdy = !flush && ((q.size() - ((exp_v && rsp_ready) ? 1 : 0)) < DEPTH);
            chk(rsp_valid == exp_v, "rsp_valid", 32'(rsp_valid), 32'(exp_v));
            chk(req_ready == exp_rdy, "req_ready", 32'(req_ready), 32'(exp_rdy));
            if (exp_v && rsp_valid) begin
                chk(rsp_pc == q[0].pc, "rsp_pc", rsp_pc, q[0].pc);
                chk(rsp_instr == q[0].instr, "rsp_instr", rsp_instr, q[0].instr);
                chk(rsp_err == q[0].err, "rsp_err", 32'(rsp_err), 32'(q[0].err));
            end else if (!exp_v) begin
                chk({rsp_pc, rsp_instr, rsp_err} == 65'h0, "rsp_gated",
                    rsp_pc | rsp_instr | 32'(rsp_err), 32'h0);
            end
            acc = req_valid && req_ready;
            e   = model_err(req_pc);
            chk(mem_en == (acc && !e), "mem_en", 32'(mem_en), 32'(acc && !e));
            if (acc && !e)
                chk(mem_addr == AW'(req_pc / 4), "mem_addr", 32'(mem_addr), req_pc / 4);
            if (flush) begin
                q.delete();
            end else begin
                if (exp_pop) void'(q.pop_front());
                if (acc) begin
                    ent.pc      = req_pc;
                    ent.err     = e;
                    ent.instr   = e ? NOP : rom[(req_pc / 4) % (1 << AW)];
                    ent.acc_cyc = cyc;
                    q.push_back(ent);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one address and hold it until accepted (bounded).
    task automatic send(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                return;
            end
        end
        chk(1'b0, "send_timeout", pc, 32'h0);
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned r = $urandom % 16;
        if (r == 0)      return $urandom;
        else if (r == 1) return (($urandom % (1 << AW)) << 2) | ($urandom % 3 + 1);
        else if (r == 2) return (($urandom % (1 << AW)) + (1 << AW)) << 2;
        else             return ($urandom % (1 << AW)) << 2;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Streaming fetch with decode always ready.
        rsp_ready = 1'b1;
        send(32'h0); send(32'h4); send(32'h8); send(32'hC);
        idle(4);

        // Back-pressure: two accepted, third waits for decode.
        rsp_ready = 1'b0;
        send(32'h0); send(32'h4);
        fork
            send(32'h8);
            begin idle(4); rsp_ready = 1'b1; end
        join
        idle(4);

        // Flush one cycle after the second accept.
        send(32'h10); send(32'h14);
        flush = 1'b1; idle(1); flush = 1'b0;
        send(32'h40);
        idle(4);

        // Misaligned and out-of-range fetches.
        send(32'h6);
        send(32'(4 << AW));
        idle(4);

        // Reset with the FIFO full.
        rsp_ready = 1'b0;
        send(32'h0); send(32'h4);
        idle(2);
        rst_n = 1'b0; idle(2);
        rst_n = 1'b1; rsp_ready = 1'b1;
        send(32'h0);
        idle(4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 4) != 0;
            req_pc    = rand_pc();
            rsp_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 32) == 0;
            rst_n     = ($urandom % 300) != 0;
            idle(1);
        end

        req_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; rsp_ready = 1'b1;
        idle(10);
        chk(q.size() == 0, "drain_empty", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ifetch_unit
`default_nettype wire
